// File: rtl/hw_qsys_timer_pkg.sv
// Shared definitions for the multi-channel interval timer bank.
// Holds the per-channel register offsets, CONTROL/STATUS bit positions and
// the helper that locates the global PENDING word after the channel blocks.
package hw_qsys_timer_pkg;

  // Word offsets within a 4-word channel block
  localparam logic [1:0] REG_STATUS  = 2'd0;
  localparam logic [1:0] REG_CONTROL = 2'd1;
  localparam logic [1:0] REG_PERIOD  = 2'd2;
  localparam logic [1:0] REG_SNAP    = 2'd3;

  // CONTROL bits; START/STOP are write-only strobes
  localparam int unsigned CTRL_ITO     = 0;
  localparam int unsigned CTRL_CONT    = 1;
  localparam int unsigned CTRL_START   = 2;
  localparam int unsigned CTRL_STOP    = 3;
  localparam int unsigned CTRL_PSC_LSB = 8;
  localparam int unsigned CTRL_PSC_MSB = 15;

  // STATUS bits
  localparam int unsigned STAT_TO  = 0;
  localparam int unsigned STAT_RUN = 1;

  // PENDING sits directly after the last channel block
  function automatic int unsigned pending_word(input int unsigned num_ch);
    return 4 * num_ch;
  endfunction

endpackage

// File: rtl/hw_qsys_timer_channel.sv
// One down-counting interval timer channel.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   status_wr           write strobe for STATUS (clears to)
//   control_wr          write strobe for CONTROL (ito/cont/prescale, start/stop strobes)
//   period_wr           write strobe for PERIOD (forces a reload on the next cycle)
//   snap_wr             write strobe for SNAP (captures the counter)
//   to_clr              clear of to from the global PENDING register
//   writedata           bus write data
//   status_word .. snap_word  read-back words, zero-extended to DATA_W
//   irq_ch              to & ito
module hw_qsys_timer_channel
  import hw_qsys_timer_pkg::*;
#(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned RESET_PERIOD = 125000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              status_wr,
  input  logic              control_wr,
  input  logic              period_wr,
  input  logic              snap_wr,
  input  logic              to_clr,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] status_word,
  output logic [DATA_W-1:0] control_word,
  output logic [DATA_W-1:0] period_word,
  output logic [DATA_W-1:0] snap_word,
  output logic              irq_ch
);

  localparam int unsigned PscW = CTRL_PSC_MSB - CTRL_PSC_LSB + 1;

  logic             ito_q, cont_q;
  logic [PscW-1:0]  prescale_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PscW-1:0]  psc_q, psc_d;
  logic             run_q, run_d;
  logic             to_q, to_d;
  logic [CNT_W-1:0] snap_q;
  logic             reload_q;  // PERIOD was written last cycle
  logic             zero_q;    // registered cnt==0 for edge detection

  logic tick, at_zero, timeout, one_shot_stop, start, stop;

  always_comb begin
    tick          = run_q && (psc_q == prescale_q);
    at_zero       = (cnt_q == '0);
    timeout       = at_zero && !zero_q;
    one_shot_stop = timeout && !cont_q;
    start         = control_wr && writedata[CTRL_START];
    stop          = control_wr && writedata[CTRL_STOP];

    // start wins over every reason to stop
    run_d = run_q;
    if (start) begin
      run_d = 1'b1;
    end else if (stop || reload_q || one_shot_stop) begin
      run_d = 1'b0;
    end

    psc_d = psc_q;
    if (start || reload_q) begin
      psc_d = '0;
    end else if (run_q) begin
      psc_d = tick ? '0 : psc_q + PscW'(1);
    end

    // A one-shot timeout parks the counter at 0; the next start reloads it
    cnt_d = cnt_q;
    if (reload_q) begin
      cnt_d = period_q;
    end else if (tick && !one_shot_stop) begin
      cnt_d = at_zero ? period_q : cnt_q - CNT_W'(1);
    end

    // A new timeout beats a simultaneous clear so no event is lost
    to_d = to_q;
    if (timeout) begin
      to_d = 1'b1;
    end else if (status_wr || to_clr) begin
      to_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ito_q      <= 1'b0;
      cont_q     <= 1'b0;
      prescale_q <= '0;
      period_q   <= CNT_W'(RESET_PERIOD);
      cnt_q      <= CNT_W'(RESET_PERIOD);
      psc_q      <= '0;
      run_q      <= 1'b0;
      to_q       <= 1'b0;
      snap_q     <= '0;
      reload_q   <= 1'b0;
      zero_q     <= (RESET_PERIOD == 0);
    end else begin
      if (control_wr) begin
        ito_q      <= writedata[CTRL_ITO];
        cont_q     <= writedata[CTRL_CONT];
        prescale_q <= writedata[CTRL_PSC_MSB:CTRL_PSC_LSB];
      end
      if (period_wr) begin
        period_q <= writedata[CNT_W-1:0];
      end
      if (snap_wr) begin
        snap_q <= cnt_q;
      end
      reload_q <= period_wr;
      zero_q   <= at_zero;
      cnt_q    <= cnt_d;
      psc_q    <= psc_d;
      run_q    <= run_d;
      to_q     <= to_d;
    end
  end

  always_comb begin
    status_word           = '0;
    status_word[STAT_TO]  = to_q;
    status_word[STAT_RUN] = run_q;

    control_word                             = '0;
    control_word[CTRL_ITO]                   = ito_q;
    control_word[CTRL_CONT]                  = cont_q;
    control_word[CTRL_PSC_MSB:CTRL_PSC_LSB]  = prescale_q;

    period_word            = '0;
    period_word[CNT_W-1:0] = period_q;

    snap_word            = '0;
    snap_word[CNT_W-1:0] = snap_q;
  end

  assign irq_ch = to_q & ito_q;

endmodule

// File: rtl/hw_qsys_multi_timer.sv
// Avalon-MM slave holding NUM_CH independent interval timers.
// Channel c occupies words 4c..4c+3 (STATUS, CONTROL, PERIOD, SNAP); word 4*NUM_CH is the
// write-1-to-clear PENDING register; all other words read 0.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   address        word address
//   chipselect     slave select
//   write_n        active-low write strobe
//   writedata      write data
//   readdata       registered read data, one cycle after address, chipselect ignored
//   irq            OR over channels of (to & ito)
module hw_qsys_multi_timer
  import hw_qsys_timer_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned RESET_PERIOD = 125000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              irq
);

  localparam logic [ADDR_W-1:0] PendAddr = ADDR_W'(pending_word(NUM_CH));

  logic              wr_en;
  logic              pend_wr;
  logic [ADDR_W-3:0] ch_idx;
  logic [1:0]        reg_sel;

  logic [DATA_W-1:0] status_w  [NUM_CH];
  logic [DATA_W-1:0] control_w [NUM_CH];
  logic [DATA_W-1:0] period_w  [NUM_CH];
  logic [DATA_W-1:0] snap_w    [NUM_CH];
  logic [NUM_CH-1:0] irq_vec;

  logic [DATA_W-1:0] pend_word;
  logic [DATA_W-1:0] rd_mux;
  logic [DATA_W-1:0] readdata_q;

  assign wr_en   = chipselect && !write_n;
  assign pend_wr = wr_en && (address == PendAddr);
  assign ch_idx  = address[ADDR_W-1:2];
  assign reg_sel = address[1:0];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic ch_wr;
    assign ch_wr = wr_en && (ch_idx == (ADDR_W-2)'(c));

    hw_qsys_timer_channel #(
      .CNT_W        (CNT_W),
      .DATA_W       (DATA_W),
      .RESET_PERIOD (RESET_PERIOD)
    ) u_channel (
      .clk          (clk),
      .reset_n      (reset_n),
      .status_wr    (ch_wr && (reg_sel == REG_STATUS)),
      .control_wr   (ch_wr && (reg_sel == REG_CONTROL)),
      .period_wr    (ch_wr && (reg_sel == REG_PERIOD)),
      .snap_wr      (ch_wr && (reg_sel == REG_SNAP)),
      .to_clr       (pend_wr && writedata[c]),
      .writedata    (writedata),
      .status_word  (status_w[c]),
      .control_word (control_w[c]),
      .period_word  (period_w[c]),
      .snap_word    (snap_w[c]),
      .irq_ch       (irq_vec[c])
    );
  end

  always_comb begin
    pend_word = '0;
    rd_mux    = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      pend_word[c] = status_w[c][STAT_TO];
    end
    if (address == PendAddr) begin
      rd_mux = pend_word;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (ch_idx == (ADDR_W-2)'(c)) begin
          case (reg_sel)
            REG_STATUS:  rd_mux = status_w[c];
            REG_CONTROL: rd_mux = control_w[c];
            REG_PERIOD:  rd_mux = period_w[c];
            default:     rd_mux = snap_w[c];
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
    end else begin
      readdata_q <= rd_mux;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |irq_vec;

endmodule

// File: tb/tb_hw_qsys_multi_timer.sv
// Directed bench for hw_qsys_multi_timer. Inputs change on the falling edge, outputs are
// sampled on the falling edge; each wr() spans exactly one rising edge.
module tb_hw_qsys_multi_timer;

  logic        clk;
  logic        reset_n;
  logic [4:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  int n_asserts = 0;
  int n_fail    = 0;
  logic [31:0] v;

  hw_qsys_multi_timer #(
    .NUM_CH       (4),
    .CNT_W        (32),
    .DATA_W       (32),
    .ADDR_W       (5),
    .RESET_PERIOD (125000)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the write lands on the next rising edge
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    clk        = 1'b0;
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    cyc(3);
    reset_n = 1'b1;

    // Reset state
    chk("reset_readdata", readdata, 32'd0);
    chk("reset_irq", 32'(irq), 32'd0);
    for (int a = 0; a < 16; a++) begin
      rd(5'(a), v);
      chk($sformatf("reset_word%0d", a), v, (a % 4 == 2) ? 32'd125000 : 32'd0);
    end
    rd(5'd16, v);
    chk("reset_pending", v, 32'd0);

    // Read latency: readdata only follows address after a rising edge
    rd(5'd1, v);
    address = 5'd2;
    #1;
    chk("latency_old", readdata, 32'd0);
    @(negedge clk);
    chk("latency_new", readdata, 32'd125000);

    // ch0: period 9, continuous, ito, prescale 0 -> timeout every 10 clocks
    wr(5'd2, 32'd9);
    wr(5'd1, 32'h7);                // start edge S
    cyc(9);
    chk("ch0_before_to", 32'(irq), 32'd0);
    cyc(1);
    chk("ch0_to_at_10", 32'(irq), 32'd1);
    wr(5'd0, 32'd0);                // STATUS write clears to
    chk("ch0_status_clr", 32'(irq), 32'd0);
    cyc(8);
    chk("ch0_before_to2", 32'(irq), 32'd0);
    cyc(1);
    chk("ch0_to_at_20", 32'(irq), 32'd1);
    wr(5'd1, 32'h8);                // stop, ito off
    chk("ch0_ito_off", 32'(irq), 32'd0);
    wr(5'd16, 32'h1);
    rd(5'd0, v);
    chk("ch0_status_idle", v, 32'd0);
    rd(5'd2, v);
    chk("ch0_period_rb", v, 32'd9);

    // ch1: period 3, prescale 4, one-shot, ito -> 3 ticks of 5 clocks, to one clock later
    wr(5'd6, 32'd3);
    wr(5'd5, 32'h405);
    cyc(15);
    chk("ch1_before_to", 32'(irq), 32'd0);
    cyc(1);
    chk("ch1_to", 32'(irq), 32'd1);
    rd(5'd4, v);
    chk("ch1_status_oneshot", v, 32'h1);
    rd(5'd5, v);
    chk("ch1_control_rb", v, 32'h401);
    wr(5'd7, 32'd0);
    rd(5'd7, v);
    chk("ch1_snap_zero", v, 32'd0);
    wr(5'd4, 32'd0);
    chk("ch1_clr", 32'(irq), 32'd0);

    // ch2: PERIOD write mid-count stops and reloads
    wr(5'd10, 32'd1000);
    wr(5'd9, 32'h4);
    cyc(20);
    rd(5'd8, v);
    chk("ch2_running", v, 32'h2);
    wr(5'd10, 32'd50);
    cyc(1);
    wr(5'd11, 32'd0);
    rd(5'd11, v);
    chk("ch2_reload_cnt", v, 32'd50);
    rd(5'd8, v);
    chk("ch2_stopped", v, 32'd0);

    // start+stop together -> runs; stop alone -> frozen two ticks later at 48
    wr(5'd9, 32'hC);
    rd(5'd8, v);
    chk("ch2_start_wins", v, 32'h2);
    wr(5'd9, 32'h8);
    rd(5'd8, v);
    chk("ch2_stop", v, 32'd0);
    cyc(5);
    wr(5'd11, 32'd0);
    rd(5'd11, v);
    chk("ch2_frozen_cnt", v, 32'd48);

    // ch3: timeout coincides with PENDING clear -> to survives
    wr(5'd14, 32'd4);
    wr(5'd13, 32'h7);               // start edge S, timeout lands on S+5
    cyc(4);
    wr(5'd16, 32'h8);
    chk("ch3_to_beats_clr", 32'(irq), 32'd1);
    rd(5'd16, v);
    chk("ch3_pending", v, 32'h8);
    wr(5'd16, 32'h8);
    chk("ch3_pending_clr", 32'(irq), 32'd0);
    wr(5'd13, 32'h8);
    rd(5'd16, v);
    chk("pending_all_clear", v, 32'd0);

    // Unmapped words
    rd(5'd17, v);
    chk("unmapped_17", v, 32'd0);
    rd(5'd31, v);
    chk("unmapped_31", v, 32'd0);

    // Async reset mid-count
    wr(5'd2, 32'd9);
    wr(5'd1, 32'h7);
    cyc(12);
    chk("pre_reset_irq", 32'(irq), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_irq", 32'(irq), 32'd0);
    chk("async_readdata", readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(5'd2, v);
    chk("post_reset_period", v, 32'd125000);
    rd(5'd1, v);
    chk("post_reset_control", v, 32'd0);
    rd(5'd0, v);
    chk("post_reset_status", v, 32'd0);
    rd(5'd3, v);
    chk("post_reset_snap", v, 32'd0);
    rd(5'd16, v);
    chk("post_reset_pending", v, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
